fre_gate_ctrl: RTL and testbench
================================

# fre_gate_ctrl

Measurement sequencer for the oscilloscope frequency counter. It generates the counting gate, clear and latch strobes for the BCD edge-counter datapath, all locked to `clk100`, so the datapath no longer relies on a divided clock. It picks the gate length (1 s / 100 ms / 10 ms) and, when enabled, auto-ranges on counter overflow or low count. It sits between the edge-counter datapath and the display formatter, and reports the active range so the decimal point can be placed.

## Interface
- `GATE_BASE`, 100_000_000: gate length in `clk100` cycles for range 0; range r uses GATE_BASE/10^r.
- `SETTLE_CYC`, 4: cycles between gate fall and result evaluation; covers the datapath synchronizer latency. Must be ≥1.
- `clk100`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  synchronous, active-low reset.
- `run`  in  1  continuous measurement enable.
- `range_sel`  in  2  manual range (0 = 1 s, 1 = 100 ms, 2 = 10 ms); value 3 is treated as 2.
- `cnt_ovf`  in  1  datapath: count exceeded 999999 during the gate (sticky until `cnt_clr`).
- `cnt_low`  in  1  datapath: count < 1000.
- `gate_en`  out  1  datapath counts input edges only while high.
- `cnt_clr`  out  1  one-cycle pulse; zeroes the datapath counters and `cnt_ovf`.
- `latch`  out  1  one-cycle pulse; datapath copies its counters to the display registers.
- `meas_valid`  out  1  one-cycle pulse, the same cycle as `latch`.
- `range`  out  2  range of the gate that produced the latched (or in-progress) result.
- `over_range`  out  1  latched result saturated (overflow at range 2).
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, CLEAR, GATE, SETTLE, EVAL, LATCH. All outputs are registered and decoded from the state.
- IDLE:
  - `range` loads `range_sel` (clamped) when the autorange macro is absent, or holds its value when the macro is present.
  - `run`=1 → CLEAR.
- CLEAR: `cnt_clr`=1 for 1 cycle → GATE.
- GATE:
  - `gate_en`=1 for exactly GATE_BASE/10^range cycles; a 27-bit down-counter is loaded at CLEAR.
  - When it expires → SETTLE.
- SETTLE: `gate_en`=0 for SETTLE_CYC cycles → EVAL.
- EVAL (1 cycle) samples `cnt_ovf` and `cnt_low`. With autorange:
  - `cnt_ovf`=1 and range<2 → range+1, no latch → CLEAR.
  - `cnt_ovf`=1 and range=2 → LATCH with `over_range`=1.
  - `cnt_low`=1 and range>0 → LATCH; range−1 takes effect after LATCH.
  - Otherwise → LATCH with range unchanged.
- EVAL without autorange: → LATCH; `over_range` = `cnt_ovf`.
- LATCH:
  - `latch` and `meas_valid` are high for 1 cycle; `over_range` updates in the same cycle.
  - `run`=1 → CLEAR, otherwise → IDLE.
- If `cnt_ovf` and `cnt_low` are both high (datapath fault), `cnt_ovf` wins.
- `run` dropping in CLEAR, GATE or SETTLE aborts the measurement: → IDLE with no latch, and `range`/`over_range` are kept. A `run` drop in EVAL or LATCH lets that measurement complete.

## Timing
- Reset (`rst_n`=0 at an edge) gives, from the next cycle: state IDLE, `gate_en`=`cnt_clr`=`latch`=`meas_valid`=`busy`=0, `range`=0, `over_range`=0. Reset mid-gate behaves the same; there is no partial latch.
- `run` sampled high at edge k in IDLE → `cnt_clr` high during cycle k+1. `gate_en` is high during cycles k+2 … k+1+G, where G = GATE_BASE/10^range.
- `gate_en` falls → `latch`/`meas_valid` pulse SETTLE_CYC+1 cycles later.
- Back-to-back period with `run` held high: G + SETTLE_CYC + 3 cycles.
- An overflow retry adds G_new + SETTLE_CYC + 2 cycles before the next latch.
- `run` low at edge j during GATE → `gate_en`=0 and `busy`=0 from cycle j+1.

## Configuration
- `FRE_AUTORANGE_EN` defined:
  - Range is adapted in EVAL as above.
  - `range_sel` is ignored.
  - Range starts at 0 after reset.
- `FRE_AUTORANGE_EN` undefined:
  - Range follows `range_sel`, sampled in IDLE only; changes during a run are ignored until the next IDLE.
  - No retries; every completed gate latches.
  - `cnt_low` is ignored.

## Test plan
All scenarios use GATE_BASE=1000, SETTLE_CYC=4.
- Autorange, `run`=1, `cnt_ovf`=`cnt_low`=0 → `cnt_clr` pulse, then `gate_en` high exactly 1000 cycles, then `latch`+`meas_valid` 5 cycles after the gate falls; `range`=0; period 1007 cycles.
- Autorange, `cnt_ovf`=1 at EVAL at range 0 → no `latch`; `range`=1; next `cnt_clr` the cycle after EVAL; next gate is 100 cycles.
- Autorange at range 2 with `cnt_ovf`=1 → `latch` with `over_range`=1; `range` stays 2. Next measurement with `cnt_low`=1 → `latch` with `over_range`=0; the following gate is 100 cycles.
- `run` dropped at gate cycle 500 → `gate_en`=0 and `busy`=0 next cycle; no `latch` within 2000 cycles.
- `rst_n`=0 during SETTLE → all outputs at reset values next cycle; with `run` still 1 after release, a fresh 1000-cycle gate starts.
- Macro undefined, `range_sel`=3 → 10-cycle gates; `cnt_ovf`=1 gives `latch` with `over_range`=1 and no retry; changing `range_sel` to 0 mid-run has no effect until after IDLE.

Source files
------------

// File: rtl/fre_gate_ctrl.sv
// Frequency-counter measurement sequencer: gate, clear and latch strobes locked to clk100.
// Optional autoranging on overflow / low count is enabled by defining FRE_AUTORANGE_EN.
module fre_gate_ctrl #(
  parameter int unsigned GATE_BASE  = 100_000_000,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic       clk100,
  input  logic       rst_n,
  input  logic       run,
  input  logic [1:0] range_sel,
  input  logic       cnt_ovf,
  input  logic       cnt_low,
  output logic       gate_en,
  output logic       cnt_clr,
  output logic       latch,
  output logic       meas_valid,
  output logic [1:0] range,
  output logic       over_range,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StGate,
    StSettle,
    StEval,
    StLatch
  } state_e;

  // Counters hold "cycles remaining minus one" so expiry is a compare against zero.
  localparam logic [26:0] Gate0Last  = 27'(GATE_BASE - 1);
  localparam logic [26:0] Gate1Last  = 27'((GATE_BASE / 10) - 1);
  localparam logic [26:0] Gate2Last  = 27'((GATE_BASE / 100) - 1);
  localparam logic [26:0] SettleLast = 27'(SETTLE_CYC - 1);

  state_e      state_q, state_d;
  logic [26:0] cnt_q, cnt_d;
  logic [1:0]  range_q, range_d;
  logic        over_range_q, over_range_d;
  logic        dec_pend_q, dec_pend_d;
  logic        gate_en_q, cnt_clr_q, latch_q, busy_q;
  logic [26:0] gate_last;

  always_comb begin
    case (range_q)
      2'd0:    gate_last = Gate0Last;
      2'd1:    gate_last = Gate1Last;
      default: gate_last = Gate2Last;
    endcase
  end

`ifdef FRE_AUTORANGE_EN
  logic [1:0] unused_range_sel;
  assign unused_range_sel = range_sel;
`else
  logic unused_cnt_low;
  assign unused_cnt_low = cnt_low;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    range_d      = range_q;
    over_range_d = over_range_q;
    dec_pend_d   = dec_pend_q;
    unique case (state_q)
      StIdle: begin
`ifndef FRE_AUTORANGE_EN
        range_d = (range_sel == 2'd3) ? 2'd2 : range_sel;
`endif
        if (run) state_d = StClear;
      end
      StClear: begin
        if (!run) begin
          state_d = StIdle;
        end else begin
          state_d = StGate;
          cnt_d   = gate_last;
        end
      end
      StGate: begin
        if (!run) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StSettle;
          cnt_d   = SettleLast;
        end else begin
          cnt_d = cnt_q - 27'd1;
        end
      end
      StSettle: begin
        if (!run) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StEval;
        end else begin
          cnt_d = cnt_q - 27'd1;
        end
      end
      StEval: begin
`ifdef FRE_AUTORANGE_EN
        if (cnt_ovf && range_q != 2'd2) begin
          // Retry on a shorter gate without presenting the saturated result.
          range_d = range_q + 2'd1;
          state_d = StClear;
        end else begin
          state_d      = StLatch;
          over_range_d = cnt_ovf;
          dec_pend_d   = !cnt_ovf && cnt_low && (range_q != 2'd0);
        end
`else
        state_d      = StLatch;
        over_range_d = cnt_ovf;
`endif
      end
      StLatch: begin
        state_d    = run ? StClear : StIdle;
        // Range drops only after the current result is latched with its own range.
        if (dec_pend_q) range_d = range_q - 2'd1;
        dec_pend_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      range_q      <= 2'd0;
      over_range_q <= 1'b0;
      dec_pend_q   <= 1'b0;
      gate_en_q    <= 1'b0;
      cnt_clr_q    <= 1'b0;
      latch_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      range_q      <= range_d;
      over_range_q <= over_range_d;
      dec_pend_q   <= dec_pend_d;
      gate_en_q    <= (state_d == StGate);
      cnt_clr_q    <= (state_d == StClear);
      latch_q      <= (state_d == StLatch);
      busy_q       <= (state_d != StIdle);
    end
  end

  assign gate_en    = gate_en_q;
  assign cnt_clr    = cnt_clr_q;
  assign latch      = latch_q;
  assign meas_valid = latch_q;
  assign range      = range_q;
  assign over_range = over_range_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fre_gate_ctrl.sv
// Directed bench for fre_gate_ctrl with GATE_BASE=1000, SETTLE_CYC=4.
// Autorange scenarios run when FRE_AUTORANGE_EN is defined, manual-range scenarios otherwise.
module tb_fre_gate_ctrl;

  logic       clk100 = 1'b0;
  logic       rst_n;
  logic       run;
  logic [1:0] range_sel;
  logic       cnt_ovf;
  logic       cnt_low;
  logic       gate_en;
  logic       cnt_clr;
  logic       latch;
  logic       meas_valid;
  logic [1:0] range;
  logic       over_range;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  fre_gate_ctrl #(
    .GATE_BASE (1000),
    .SETTLE_CYC(4)
  ) dut (
    .clk100    (clk100),
    .rst_n     (rst_n),
    .run       (run),
    .range_sel (range_sel),
    .cnt_ovf   (cnt_ovf),
    .cnt_low   (cnt_low),
    .gate_en   (gate_en),
    .cnt_clr   (cnt_clr),
    .latch     (latch),
    .meas_valid(meas_valid),
    .range     (range),
    .over_range(over_range),
    .busy      (busy)
  );

  always #5 clk100 = ~clk100;

  task automatic tick();
    @(posedge clk100);
    #1;
    cyc++;
  endtask

  // Follows one measurement: waits for cnt_clr, counts gate cycles, then reports the
  // delay from the first gate-low cycle to either latch or a retry cnt_clr.
  task automatic meas(output int t_clr, output int glen, output int dly, output logic retry,
                      output logic mv, output logic ovr, output logic [1:0] rng);
    t_clr = -1; glen = -1; dly = -1; retry = 1'b0; mv = 1'b0; ovr = 1'b0; rng = 2'd0;
    for (int i = 0; i < 4000 && !cnt_clr; i++) tick();
    if (!cnt_clr) return;
    t_clr = cyc;
    tick();
    glen = 0;
    while (gate_en && glen < 4000) begin
      glen++;
      tick();
    end
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (latch) begin
        dly = i; mv = meas_valid; ovr = over_range; rng = range;
        return;
      end
      if (cnt_clr) begin
        dly = i; retry = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && busy; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; range_sel = 2'd0; cnt_ovf = 1'b0; cnt_low = 1'b0;
    repeat (3) tick();
    n_vec++; if (gate_en !== 1'b0) begin n_err++; $display("FAIL reset_gate_en got %b want 0", gate_en); end
    n_vec++; if (cnt_clr !== 1'b0) begin n_err++; $display("FAIL reset_cnt_clr got %b want 0", cnt_clr); end
    n_vec++; if (latch !== 1'b0) begin n_err++; $display("FAIL reset_latch got %b want 0", latch); end
    n_vec++; if (meas_valid !== 1'b0) begin n_err++; $display("FAIL reset_meas_valid got %b want 0", meas_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (range !== 2'd0) begin n_err++; $display("FAIL reset_range got %0d want 0", range); end
    n_vec++; if (over_range !== 1'b0) begin n_err++; $display("FAIL reset_over_range got %b want 0", over_range); end
  endtask

  task automatic test_basic();
    int t0, t1, t2, g, d;
    logic r, mv, o;
    logic [1:0] rg;
    rst_n = 1'b1;
    tick();
    run = 1'b1;
    t0 = cyc;
    tick();
    n_vec++; if (cnt_clr !== 1'b1) begin n_err++; $display("FAIL clr_latency got %b want 1", cnt_clr); end
    meas(t1, g, d, r, mv, o, rg);
    n_vec++; if (t1 - t0 !== 1) begin n_err++; $display("FAIL clr_cycle got %0d want 1", t1 - t0); end
    n_vec++; if (g !== 1000) begin n_err++; $display("FAIL gate_len_r0 got %0d want 1000", g); end
    n_vec++; if (d !== 5) begin n_err++; $display("FAIL latch_delay got %0d want 5", d); end
    n_vec++; if ({r, mv, o, rg} !== {1'b0, 1'b1, 1'b0, 2'd0}) begin
      n_err++; $display("FAIL latch_flags got retry=%b mv=%b ovr=%b rng=%0d want 0 1 0 0", r, mv, o, rg);
    end
    meas(t2, g, d, r, mv, o, rg);
    n_vec++; if (t2 - t1 !== 1007) begin n_err++; $display("FAIL period got %0d want 1007", t2 - t1); end
  endtask

  task automatic test_abort();
    int seen;
    for (int i = 0; i < 2000 && !cnt_clr; i++) tick();
    repeat (500) tick();
    n_vec++; if (gate_en !== 1'b1) begin n_err++; $display("FAIL abort_pre_gate got %b want 1", gate_en); end
    run = 1'b0;
    tick();
    n_vec++; if (gate_en !== 1'b0) begin n_err++; $display("FAIL abort_gate_en got %b want 0", gate_en); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      if (latch) seen++;
      tick();
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_latch got %0d latches want 0", seen); end
  endtask

  task automatic test_reset_settle();
    int t, g, d;
    logic r, mv, o;
    logic [1:0] rg;
    run = 1'b1;
    for (int i = 0; i < 100 && !cnt_clr; i++) tick();
    tick();
    for (int i = 0; i < 2000 && gate_en; i++) tick();
    tick();
    rst_n = 1'b0;
    tick();
    n_vec++; if ({gate_en, cnt_clr, latch, meas_valid, busy, range, over_range} !== 8'd0) begin
      n_err++;
      $display("FAIL settle_reset got gate=%b clr=%b latch=%b mv=%b busy=%b rng=%0d ovr=%b want all 0",
               gate_en, cnt_clr, latch, meas_valid, busy, range, over_range);
    end
    rst_n = 1'b1;
    meas(t, g, d, r, mv, o, rg);
    n_vec++; if (g !== 1000) begin n_err++; $display("FAIL post_reset_gate got %0d want 1000", g); end
    n_vec++; if (d !== 5 || mv !== 1'b1) begin
      n_err++; $display("FAIL post_reset_latch got dly=%0d mv=%b want 5 1", d, mv);
    end
  endtask

`ifdef FRE_AUTORANGE_EN
  task automatic test_ovf_retry();
    int t, g, d;
    logic r, mv, o;
    logic [1:0] rg;
    cnt_ovf = 1'b1;
    range_sel = 2'd2;
    meas(t, g, d, r, mv, o, rg);
    n_vec++; if (g !== 1000) begin n_err++; $display("FAIL ar_gate_r0 got %0d want 1000", g); end
    n_vec++; if (r !== 1'b1 || d !== 5) begin
      n_err++; $display("FAIL ar_retry0 got retry=%b dly=%0d want 1 5", r, d);
    end
    n_vec++; if (range !== 2'd1) begin n_err++; $display("FAIL ar_range_up got %0d want 1", range); end
    meas(t, g, d, r, mv, o, rg);
    n_vec++; if (g !== 100 || r !== 1'b1) begin
      n_err++; $display("FAIL ar_gate_r1 got len=%0d retry=%b want 100 1", g, r);
    end
    meas(t, g, d, r, mv, o, rg);
    n_vec++; if (g !== 10) begin n_err++; $display("FAIL ar_gate_r2 got %0d want 10", g); end
    n_vec++; if ({r, mv, o, rg} !== {1'b0, 1'b1, 1'b1, 2'd2}) begin
      n_err++; $display("FAIL ar_sat got retry=%b mv=%b ovr=%b rng=%0d want 0 1 1 2", r, mv, o, rg);
    end
  endtask

  task automatic test_low_down();
    int t, g, d;
    logic r, mv, o;
    logic [1:0] rg;
    cnt_ovf = 1'b0;
    cnt_low = 1'b1;
    meas(t, g, d, r, mv, o, rg);
    n_vec++; if ({g, r, mv, o, rg} !== {32'd10, 1'b0, 1'b1, 1'b0, 2'd2}) begin
      n_err++; $display("FAIL ar_low got len=%0d retry=%b mv=%b ovr=%b rng=%0d want 10 0 1 0 2",
                        g, r, mv, o, rg);
    end
    cnt_low = 1'b0;
    meas(t, g, d, r, mv, o, rg);
    n_vec++; if (g !== 100 || rg !== 2'd1) begin
      n_err++; $display("FAIL ar_range_down got len=%0d rng=%0d want 100 1", g, rg);
    end
  endtask
`else
  task automatic test_range_clamp();
    int t, g, d;
    logic r, mv, o;
    logic [1:0] rg;
    run = 1'b0;
    wait_idle();
    range_sel = 2'd3;
    cnt_ovf = 1'b1;
    tick();
    run = 1'b1;
    meas(t, g, d, r, mv, o, rg);
    n_vec++; if (g !== 10) begin n_err++; $display("FAIL clamp_gate got %0d want 10", g); end
    n_vec++; if ({r, d, mv, o, rg} !== {1'b0, 32'd5, 1'b1, 1'b1, 2'd2}) begin
      n_err++; $display("FAIL manual_ovf got retry=%b dly=%0d mv=%b ovr=%b rng=%0d want 0 5 1 1 2",
                        r, d, mv, o, rg);
    end
  endtask

  task automatic test_range_hold();
    int t, g, d;
    logic r, mv, o;
    logic [1:0] rg;
    range_sel = 2'd0;
    cnt_ovf = 1'b0;
    cnt_low = 1'b1;
    meas(t, g, d, r, mv, o, rg);
    n_vec++; if ({g, r, o, rg} !== {32'd10, 1'b0, 1'b0, 2'd2}) begin
      n_err++; $display("FAIL hold_mid_run got len=%0d retry=%b ovr=%b rng=%0d want 10 0 0 2",
                        g, r, o, rg);
    end
    run = 1'b0;
    cnt_low = 1'b0;
    wait_idle();
    tick();
    n_vec++; if (range !== 2'd0) begin n_err++; $display("FAIL idle_reload got %0d want 0", range); end
    range_sel = 2'd1;
    run = 1'b1;
    meas(t, g, d, r, mv, o, rg);
    n_vec++; if (g !== 100 || rg !== 2'd1) begin
      n_err++; $display("FAIL gate_r1 got len=%0d rng=%0d want 100 1", g, rg);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_reset_settle();
`ifdef FRE_AUTORANGE_EN
    test_ovf_retry();
    test_low_down();
`else
    test_range_clamp();
    test_range_hold();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
